// File: rtl/dmem_resp_ctrl_if.sv
// Load/store <-> data-memory responder handshake bundle.
// The pipeline drives the request; the responder returns the doubleword, finish and err.
interface dmem_resp_ctrl_if;
  logic [63:0] mem_addr_i;
  logic        mem_re_i;
  logic [2:0]  mem_re_type_i;
  logic        mem_we_i;
  logic [2:0]  mem_we_type_i;
  logic [7:0]  mem_wmask_i;
  logic [63:0] mem_wdata_i;
  logic        fence_i;
  logic [63:0] mem_rdata_o;
  logic        mem_finish_o;
  logic        mem_err_o;

  modport master (
    output mem_addr_i, mem_re_i, mem_re_type_i, mem_we_i, mem_we_type_i,
           mem_wmask_i, mem_wdata_i, fence_i,
    input  mem_rdata_o, mem_finish_o, mem_err_o
  );

  modport slave (
    input  mem_addr_i, mem_re_i, mem_re_type_i, mem_we_i, mem_we_type_i,
           mem_wmask_i, mem_wdata_i, fence_i,
    output mem_rdata_o, mem_finish_o, mem_err_o
  );
endinterface

// File: rtl/dmem_resp_ctrl.sv
// Data-memory responder: services one held read/write/fence from a 64-bit SRAM
// model after a fixed latency and returns the aligned doubleword with a finish pulse.
module dmem_resp_ctrl #(
  parameter logic [63:0] ADDR_BASE    = 64'h8000_0000,
  parameter int          DEPTH_DW     = 4096,
  parameter int          LATENCY      = 2,
  parameter int          FENCE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  dmem_resp_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_DW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FENCE = 2'd2
  } op_t;

  state_t            state_r;
  op_t               op_r;
  logic [3:0]        cnt_r;
  logic [63:0]       addr_r;
  logic [2:0]        type_r;
  logic [7:0]        mask_r;
  logic [63:0]       wdata_r;
  logic [63:0]       rdata_r;
  logic              finish_r;
  logic              err_r;
  logic [63:0]       mem_r [DEPTH_DW];

  logic [63:0]       off_s;
  logic [IDX_W-1:0]  idx_s;
  logic              fault_s;
  logic              access_s;
  logic              wr_en_s;

  // Natural-alignment check per access size; unknown encodings (incl. 111) always fault.
  function automatic logic align_fault(input logic [2:0] typ, input logic [2:0] a);
    case (typ)
      3'b000:  return 1'b0;
      3'b001:  return (a[0] != 1'b0);
      3'b010:  return (a[1:0] != 2'b00);
      3'b100:  return (a != 3'b000);
      default: return 1'b1;
    endcase
  endfunction

  // Decode the latched address into an array index and a fault flag.
  always_comb begin
    off_s   = addr_r - ADDR_BASE;
    idx_s   = off_s[IDX_W+2:3];
    fault_s = (addr_r < ADDR_BASE) || ((off_s >> 3) >= 64'(DEPTH_DW)) ||
              align_fault(type_r, addr_r[2:0]);
    access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0) && !rst;
    if (access_s && (op_r == OP_WRITE) && !fault_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Byte-lane store merge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int n = 0; n < 8; n++) begin
        if (mask_r[n]) begin
          mem_r[idx_s][8*n +: 8] <= wdata_r[8*n +: 8];
        end
      end
    end
  end

  // Request FSM with registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_READ;
      cnt_r    <= 4'd0;
      addr_r   <= 64'd0;
      type_r   <= 3'b111;
      mask_r   <= 8'd0;
      wdata_r  <= 64'd0;
      rdata_r  <= 64'd0;
      finish_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          finish_r <= 1'b0;
          err_r    <= 1'b0;
          addr_r   <= bus.mem_addr_i;
          mask_r   <= bus.mem_wmask_i;
          wdata_r  <= bus.mem_wdata_i;
          if (bus.fence_i) begin
            op_r    <= OP_FENCE;
            type_r  <= 3'b111;
            cnt_r   <= 4'(FENCE_CYCLES - 1);
            state_r <= ST_WAIT;
          end else if (bus.mem_we_i) begin
            op_r    <= OP_WRITE;
            type_r  <= bus.mem_we_type_i;
            cnt_r   <= 4'(LATENCY - 1);
            state_r <= ST_WAIT;
          end else if (bus.mem_re_i) begin
            op_r    <= OP_READ;
            type_r  <= bus.mem_re_type_i;
            cnt_r   <= 4'(LATENCY - 1);
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r  <= ST_RESP;
            finish_r <= 1'b1;
            case (op_r)
              OP_READ: begin
                err_r   <= fault_s;
                rdata_r <= fault_s ? 64'd0 : mem_r[idx_s];
              end
              OP_WRITE: begin
                err_r   <= fault_s;
                rdata_r <= 64'd0;
              end
              default: begin
                err_r   <= 1'b0;
                rdata_r <= 64'd0;
              end
            endcase
          end
        end
        ST_RESP: begin
          finish_r <= 1'b0;
          err_r    <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          finish_r <= 1'b0;
          err_r    <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rdata_o  = rdata_r;
  assign bus.mem_finish_o = finish_r;
  assign bus.mem_err_o    = err_r;

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Directed bench for dmem_resp_ctrl: a vector table for single accesses plus
// hand-written back-to-back, flush and reset-abort sequences.
module tb_dmem_resp_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dmem_resp_ctrl_if bus ();

  dmem_resp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fence;
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [2:0]  rtype;
    logic [2:0]  wtype;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic f, input logic w, input logic r,
                              input logic [63:0] a, input logic [2:0] rt,
                              input logic [2:0] wt, input logic [7:0] m,
                              input logic [63:0] wd, input logic [63:0] er,
                              input logic ee, input int l);
    vec_t v;
    v.fence = f; v.we = w; v.re = r; v.addr = a; v.rtype = rt; v.wtype = wt;
    v.mask = m; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.fence_i       = v.fence;
    bus.mem_we_i      = v.we;
    bus.mem_re_i      = v.re;
    bus.mem_addr_i    = v.addr;
    bus.mem_re_type_i = v.rtype;
    bus.mem_we_type_i = v.wtype;
    bus.mem_wmask_i   = v.mask;
    bus.mem_wdata_i   = v.wdata;
  endtask

  task automatic clear_req();
    bus.fence_i  = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_re_i = 1'b0;
  endtask

  // Count rising edges until finish is seen on a falling edge; -1 on timeout.
  task automatic wait_finish(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_finish_o === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  int edges;
  int pulses;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.mem_addr_i    = 64'd0;
    bus.mem_re_type_i = 3'b111;
    bus.mem_we_type_i = 3'b111;
    bus.mem_wmask_i   = 8'd0;
    bus.mem_wdata_i   = 64'd0;
    clear_req();

    //             f    w    r    addr                    rt      wt      mask   wdata                  exp_rdata              err  lat
    vecs[0]  = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_0008,3'b111,3'b100,8'hFF,64'h1122334455667788,64'h0,                1'b0,2);
    vecs[1]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'h1122334455667788,1'b0,2);
    vecs[2]  = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_000B,3'b111,3'b000,8'h08,64'h00000000AA000000,64'h0,                1'b0,2);
    vecs[3]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'h11223344AA667788,1'b0,2);
    vecs[4]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0002,3'b010,3'b111,8'h00,64'h0,                64'h0,                1'b1,2);
    vecs[5]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_7FFF_FFF8,3'b100,3'b111,8'h00,64'h0,                64'h0,                1'b1,2);
    vecs[6]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'h11223344AA667788,1'b0,2);
    vecs[7]  = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_8000,3'b111,3'b100,8'hFF,64'hFFFFFFFFFFFFFFFF,64'h0,                1'b1,2);
    vecs[8]  = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_7FF8,3'b111,3'b100,8'hFF,64'hDEADBEEFCAFEF00D,64'h0,                1'b0,2);
    vecs[9]  = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_7FF8,3'b100,3'b111,8'h00,64'h0,                64'hDEADBEEFCAFEF00D,1'b0,2);
    vecs[10] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_8000,3'b100,3'b111,8'h00,64'h0,                64'h0,                1'b1,2);
    vecs[11] = mk(1'b1,1'b0,1'b0,64'h0000_0000_8000_0008,3'b111,3'b111,8'h00,64'h0,                64'h0,                1'b0,4);
    vecs[12] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b111,3'b111,8'h00,64'h0,                64'h0,                1'b1,2);
    vecs[13] = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_0009,3'b111,3'b001,8'h06,64'h0000000000FFFF00,64'h0,                1'b1,2);
    vecs[14] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'h11223344AA667788,1'b0,2);
    vecs[15] = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_0008,3'b111,3'b100,8'h00,64'h0,                64'h0,                1'b0,2);
    vecs[16] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'h11223344AA667788,1'b0,2);
    vecs[17] = mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_000E,3'b111,3'b001,8'hC0,64'hBEEF000000000000,64'h0,                1'b0,2);
    vecs[18] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'hBEEF3344AA667788,1'b0,2);
    vecs[19] = mk(1'b1,1'b1,1'b1,64'h0000_0000_8000_0008,3'b100,3'b100,8'hFF,64'h0,                64'h0,                1'b0,4);
    vecs[20] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0008,3'b100,3'b111,8'h00,64'h0,                64'hBEEF3344AA667788,1'b0,2);
    vecs[21] = mk(1'b0,1'b1,1'b1,64'h0000_0000_8000_0010,3'b100,3'b100,8'hFF,64'h0102030405060708,64'h0,                1'b0,2);
    vecs[22] = mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0010,3'b100,3'b111,8'h00,64'h0,                64'h0102030405060708,1'b0,2);

    // Reset: three cycles, all outputs low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("reset_rdata", bus.mem_rdata_o, 64'd0);
    check("reset_finish", {63'd0, bus.mem_finish_o}, 64'd0);
    check("reset_err", {63'd0, bus.mem_err_o}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      wait_finish(edges);
      check($sformatf("v%0d_latency", i), 64'(edges), 64'(vecs[i].lat + 1));
      check($sformatf("v%0d_rdata", i), bus.mem_rdata_o, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {63'd0, bus.mem_err_o}, {63'd0, vecs[i].exp_err});
      clear_req();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {62'd0, bus.mem_finish_o, bus.mem_err_o}, 64'd0);
      check($sformatf("v%0d_rdata_hold", i), bus.mem_rdata_o, vecs[i].exp_rdata);
    end

    // Back-to-back SD then LD, next request presented in the finish cycle.
    drive(mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_0018,3'b111,3'b100,8'hFF,64'hA5A5A5A55A5A5A5A,64'h0,1'b0,2));
    wait_finish(edges);
    check("b2b_sd_latency", 64'(edges), 64'd3);
    drive(mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0018,3'b100,3'b111,8'h00,64'h0,64'h0,1'b0,2));
    wait_finish(edges);
    check("b2b_ld_latency", 64'(edges), 64'd4);
    check("b2b_ld_rdata", bus.mem_rdata_o, 64'hA5A5A5A55A5A5A5A);
    clear_req();
    @(posedge clk);
    @(negedge clk);

    // Request dropped during WAIT still completes.
    drive(mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0010,3'b100,3'b111,8'h00,64'h0,64'h0,1'b0,2));
    @(posedge clk);
    @(negedge clk);
    clear_req();
    wait_finish(edges);
    check("flush_latency", 64'(edges), 64'd2);
    check("flush_rdata", bus.mem_rdata_o, 64'h0102030405060708);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of WAIT aborts the store.
    drive(mk(1'b0,1'b1,1'b0,64'h0000_0000_8000_0018,3'b111,3'b100,8'hFF,64'h0,64'h0,1'b0,2));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_req();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_rdata_reset", bus.mem_rdata_o, 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_finish_o === 1'b1) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_no_finish", 64'(pulses), 64'd0);
    drive(mk(1'b0,1'b0,1'b1,64'h0000_0000_8000_0018,3'b100,3'b111,8'h00,64'h0,64'h0,1'b0,2));
    wait_finish(edges);
    check("abort_ld_latency", 64'(edges), 64'd3);
    check("abort_ld_rdata", bus.mem_rdata_o, 64'hA5A5A5A55A5A5A5A);
    clear_req();
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
